ps2_host_tx: RTL and testbench

//  PS/2 host-to-device byte transmitter: sends one command byte (0xF4 enable reporting, 0xFF reset, ...)
//  to the mouse over the open-drain PS/2 clock/data pair, on the same pins the mouse receive path uses.

---
 rtl/ps2_host_tx_pkg.sv | 25 ++
 rtl/ps2_host_tx_if.sv | 26 ++
 rtl/ps2_host_tx_edge_sync.sv | 36 +++
 rtl/ps2_host_tx.sv | 164 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame constants, command bytes.
// Also used by the PS/2 receive path so both sides agree on framing.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_RTS     = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_ACK     = 3'd4,
        ST_WAITREL = 3'd5
    } state_e;

    localparam int FRAME_LEN = 11;

    localparam logic [7:0] CMD_ENABLE_REPORTING = 8'hF4;
    localparam logic [7:0] CMD_RESET            = 8'hFF;
    localparam logic [7:0] CMD_SET_DEFAULTS     = 8'hF6;

    // Host-shifted part of the frame: {stop, odd parity, data}; start bit is sent separately.
    function automatic logic [9:0] make_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake plus the open-drain PS/2 pin pair of the host transmitter.
// slave = transmitter side, master = sequencer / pad side.
interface ps2_host_tx_if;
    import ps2_host_tx_pkg::*;

    logic [7:0] txdata;
    logic       txstart;
    logic       busy;
    logic       txdone;
    logic       txerr;
    logic       ps2clk_in;
    logic       ps2data_in;
    logic       ps2clk_oe;
    logic       ps2data_oe;

    modport slave (
        input  txdata, txstart, ps2clk_in, ps2data_in,
        output busy, txdone, txerr, ps2clk_oe, ps2data_oe
    );

    modport master (
        output txdata, txstart, ps2clk_in, ps2data_in,
        input  busy, txdone, txerr, ps2clk_oe, ps2data_oe
    );

endinterface

// File: rtl/ps2_host_tx_edge_sync.sv
// Two-flop synchronizers for the PS/2 clock/data pins and a clock falling-edge pulse.
// Flops reset to 1 (idle bus level) so leaving reset never fakes a falling edge.
module ps2_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ps2clk_i,
    input  logic ps2data_i,
    output logic clk_sync_o,
    output logic data_sync_o,
    output logic fall_o
);

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic data_meta_q, data_sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2clk_i;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2data_i;
            data_sync_q <= data_meta_q;
        end
    end

    assign clk_sync_o  = clk_sync_q;
    assign data_sync_o = data_sync_q;
    assign fall_o      = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: clock inhibit, request-to-send, device-clocked
// shift of data/parity/stop, ack check, and a shared inhibit/timeout counter.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int CLKFREQ    = 50_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    ps2_host_tx_if.slave     bus_io
);

    localparam int INH_CYC = CLKFREQ / 1_000_000 * INHIBIT_US;
    localparam int TO_CYC  = CLKFREQ / 1000 * TIMEOUT_MS;
    localparam int CNT_MAX = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INH_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [9:0]       frame_q, frame_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic clk_sync, data_sync, fall;

    ps2_edge_sync u_sync (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ps2clk_i    (bus_io.ps2clk_in),
        .ps2data_i   (bus_io.ps2data_in),
        .clk_sync_o  (clk_sync),
        .data_sync_o (data_sync),
        .fall_o      (fall)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bitcnt_q  <= '0;
            frame_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitcnt_q  <= bitcnt_d;
            frame_q   <= frame_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitcnt_d  = bitcnt_q;
        frame_d   = frame_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (bus_io.txstart) begin
                    frame_d  = make_frame(bus_io.txdata);
                    cnt_d    = '0;
                    bitcnt_d = '0;
                    clk_oe_d = 1'b1;
                    state_d  = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                // Release clock and pull data (start bit) in the same cycle.
                if (cnt_q == INH_LAST) begin
                    cnt_d     = '0;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    state_d   = ST_RTS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RTS: begin
                if (fall) begin
                    data_oe_d = ~frame_q[0];
                    frame_d   = {1'b0, frame_q[9:1]};
                    bitcnt_d  = 4'd1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The fall that puts out the stop bit (bitcnt 9) is the 10th device fall.
                if (fall) begin
                    data_oe_d = ~frame_q[0];
                    frame_d   = {1'b0, frame_q[9:1]};
                    bitcnt_d  = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd9) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (fall) begin
                    if (data_sync) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAITREL;
                    end
                end
            end
            ST_WAITREL: begin
                if (clk_sync && data_sync) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        // Device-clocked phases share one watchdog, restarted by every falling edge.
        if (state_q == ST_RTS || state_q == ST_SHIFT ||
            state_q == ST_ACK || state_q == ST_WAITREL) begin
            if (fall) begin
                cnt_d = '0;
            end else if (cnt_q == TO_LAST) begin
                cnt_d     = '0;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                done_d    = 1'b0;
                err_d     = 1'b1;
                state_d   = ST_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign bus_io.ps2clk_oe  = clk_oe_q;
    assign bus_io.ps2data_oe = data_oe_q;
    assign bus_io.busy       = (state_q != ST_IDLE);
    assign bus_io.txdone     = done_q;
    assign bus_io.txerr      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain PS/2 device model at 12.5 kHz, scoreboard of
// expected txdone/txerr outcomes and device-sampled frames.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_host_tx_if ifc();

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic dev_abort    = 1'b0;

    assign ifc.ps2clk_in  = ~(ifc.ps2clk_oe  | dev_clk_low);
    assign ifc.ps2data_in = ~(ifc.ps2data_oe | dev_data_low);

    ps2_host_tx #(
        .CLKFREQ    (1_000_000),
        .INHIBIT_US (100),
        .TIMEOUT_MS (1)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (ifc.slave)
    );

    typedef struct packed {
        logic       is_err;
        logic       chk_frame;
        logic [9:0] frame;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         dev_falls = 0;
    logic [9:0] dev_frame = '0;
    int         inh_run = 0;
    int         last_inh = 0;
    int         rel_cyc = 0;
    int         err_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_tx(input logic is_err, input logic chk_frame, input logic [9:0] frame);
        exp_t e;
        e.is_err    = is_err;
        e.chk_frame = chk_frame;
        e.frame     = frame;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        ifc.txdata  = d;
        ifc.txstart = 1'b1;
        @(negedge clk);
        ifc.txstart = 1'b0;
    endtask

    task automatic half_period(output bit aborted);
        repeat (40) @(posedge clk);
        aborted = dev_abort;
    endtask

    // mode 0: ack, 1: no ack, 2: never clocks
    task automatic dev_run(input int mode);
        int w;
        bit ab;
        dev_frame = '0;
        w = 0;
        while (!(ifc.ps2clk_in === 1'b1 && ifc.ps2data_in === 1'b0) && w < 5000) begin
            @(posedge clk);
            w++;
        end
        if (w >= 5000) begin
            chk("rts_seen", 32'(0), 32'(1));
            return;
        end
        if (mode == 2) return;
        repeat (10) @(posedge clk);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) begin
                if (mode == 0) dev_data_low = 1'b1;
                repeat (20) @(posedge clk);
            end
            dev_clk_low = 1'b1;
            dev_falls++;
            half_period(ab);
            if (ab) break;
            dev_clk_low = 1'b0;
            if (k <= 10) dev_frame[k-1] = ifc.ps2data_in;
            if (k == 11) dev_data_low = 1'b0;
            half_period(ab);
            if (ab) break;
        end
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (ifc.busy !== 1'b0 && w < 4000) begin
            @(negedge clk);
            w++;
        end
        chk("busy_released", 32'(ifc.busy), 32'(0));
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_falls(input int target);
        int w;
        w = 0;
        while (dev_falls < target && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("falls_reached", 32'(dev_falls >= target), 32'(1));
    endtask

    // Scoreboard monitor: every txdone/txerr pulse consumes one expected outcome.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ifc.ps2clk_oe) begin
                    inh_run++;
                end else if (inh_run != 0) begin
                    last_inh = inh_run;
                    inh_run  = 0;
                    rel_cyc  = cyc;
                end
                if (ifc.txdone || ifc.txerr) begin
                    err_cyc = cyc;
                    chk("done_err_exclusive", 32'(ifc.txdone & ifc.txerr), 32'(0));
                    chk("busy_at_pulse", 32'(ifc.busy), 32'(0));
                    chk("oe_at_pulse", 32'({ifc.ps2clk_oe, ifc.ps2data_oe}), 32'(0));
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse txdone=%0d txerr=%0d required=none (t=%0t)",
                                 ifc.txdone, ifc.txerr, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pulse_is_err", 32'(ifc.txerr), 32'(e.is_err));
                        if (e.chk_frame) chk("device_frame", 32'(dev_frame), 32'(e.frame));
                    end
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog actual=expired required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        ifc.txdata  = 8'h00;
        ifc.txstart = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", 32'(ifc.ps2clk_oe), 32'(0));
        chk("rst_data_oe", 32'(ifc.ps2data_oe), 32'(0));
        chk("rst_busy", 32'(ifc.busy), 32'(0));
        chk("rst_pulses", 32'({ifc.txdone, ifc.txerr}), 32'(0));
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // F4: data LSB-first 0,0,1,0,1,1,1,1, parity 0, stop 1
        expect_tx(1'b0, 1'b1, 10'h2F4);
        send(8'hF4);
        chk("busy_after_accept", 32'(ifc.busy), 32'(1));
        dev_run(0);
        wait_idle();
        chk("inhibit_len", 32'(last_inh), 32'(100));

        // FF: eight ones, parity 1
        expect_tx(1'b0, 1'b1, 10'h3FF);
        send(8'hFF);
        dev_run(0);
        wait_idle();

        // F6 with no ack from the device
        expect_tx(1'b1, 1'b1, 10'h3F6);
        send(8'hF6);
        dev_run(1);
        wait_idle();

        // Device never clocks after request-to-send
        expect_tx(1'b1, 1'b0, 10'h000);
        send(8'hF4);
        dev_run(2);
        wait_idle();
        chk("timeout_cycles", 32'(err_cyc - rel_cyc), 32'(1000));

        // txstart with 00 during the shift must be ignored
        expect_tx(1'b0, 1'b1, 10'h2F4);
        send(8'hF4);
        base = dev_falls;
        fork
            dev_run(0);
            begin
                wait_falls(base + 4);
                repeat (5) @(negedge clk);
                ifc.txdata  = 8'h00;
                ifc.txstart = 1'b1;
                @(negedge clk);
                ifc.txstart = 1'b0;
            end
        join
        wait_idle();

        // Reset after the 4th fall releases both lines and busy at once
        send(8'hF4);
        base = dev_falls;
        fork
            dev_run(0);
            begin
                wait_falls(base + 4);
                repeat (5) @(posedge clk);
                #3;
                rst = 1'b1;
                #1;
                chk("midrst_oe", 32'({ifc.ps2clk_oe, ifc.ps2data_oe}), 32'(0));
                chk("midrst_busy", 32'(ifc.busy), 32'(0));
                dev_abort = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        dev_abort = 1'b0;
        repeat (200) @(negedge clk);

        expect_tx(1'b0, 1'b1, 10'h2F4);
        send(8'hF4);
        dev_run(0);
        wait_idle();

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
